// File: rtl/ofs_plat_shim_ccip_rd_burst_split.sv
// Splits AFU read bursts (1-64 lines) into aligned 1/2/4-line CCI-P reads and
// re-tags the in-order response stream with burst tag, SOP and EOP.
module ofs_plat_shim_ccip_rd_burst_split #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 16,
    parameter int MAX_BURSTS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [5:0]            req_len,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  c0_tx_valid,
    output logic [ADDR_WIDTH-1:0] c0_tx_addr,
    output logic [1:0]            c0_tx_cl_len,
    output logic [15:0]           c0_tx_mdata,
    input  logic                  c0_tx_almfull,
    input  logic                  rsp_in_valid,
    input  logic [DATA_WIDTH-1:0] rsp_in_data,
    output logic                  afu_rsp_valid,
    output logic [DATA_WIDTH-1:0] afu_rsp_data,
    output logic [TAG_WIDTH-1:0]  afu_rsp_tag,
    output logic                  afu_rsp_sop,
    output logic                  afu_rsp_eop,
    output logic                  err_underflow
);
    localparam int PTR_W = $clog2(MAX_BURSTS);
    localparam int ENT_W = TAG_WIDTH + 6;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [6:0]              remaining_q, remaining_d;
    logic [15:0]             seq_q, seq_d;

    logic [ENT_W-1:0]        fifo_mem [MAX_BURSTS];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          cnt_q, cnt_d;
    logic [5:0]              beat_cnt_q, beat_cnt_d;

    logic                    afu_rsp_valid_q, afu_rsp_valid_d;
    logic [DATA_WIDTH-1:0]   afu_rsp_data_q, afu_rsp_data_d;
    logic [TAG_WIDTH-1:0]    afu_rsp_tag_q, afu_rsp_tag_d;
    logic                    afu_rsp_sop_q, afu_rsp_sop_d;
    logic                    afu_rsp_eop_q, afu_rsp_eop_d;
    logic                    err_underflow_q, err_underflow_d;

    logic                    fifo_full, fifo_empty, push, pop, issue, rsp_ok;
    logic                    sop, eop;
    logic [2:0]              size_lines;
    logic [1:0]              cl_len;
    logic [ENT_W-1:0]        head;

    assign fifo_full  = (cnt_q == (PTR_W+1)'(MAX_BURSTS));
    assign fifo_empty = (cnt_q == '0);
    assign req_ready  = (state_q == IDLE) && !fifo_full;
    assign push       = req_valid && req_ready;
    assign issue      = (state_q == SPLIT) && !c0_tx_almfull;

    assign c0_tx_valid  = issue;
    assign c0_tx_addr   = cur_addr_q;
    assign c0_tx_cl_len = cl_len;
    assign c0_tx_mdata  = seq_q;

    // Largest naturally aligned chunk that fits; keeps every request inside one 4-line group.
    always_comb begin
        size_lines = 3'd1;
        cl_len     = 2'd0;
        if (cur_addr_q[1:0] == 2'b00 && remaining_q >= 7'd4) begin
            size_lines = 3'd4;
            cl_len     = 2'd3;
        end else if (!cur_addr_q[0] && remaining_q >= 7'd2) begin
            size_lines = 3'd2;
            cl_len     = 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        seq_d       = seq_q;
        if (state_q == IDLE && push) begin
            cur_addr_d  = req_addr;
            remaining_d = {1'b0, req_len} + 7'd1;
            state_d     = SPLIT;
        end else if (issue) begin
            cur_addr_d  = cur_addr_q + ADDR_WIDTH'(size_lines);
            remaining_d = remaining_q - 7'(size_lines);
            if (remaining_q == 7'(size_lines)) begin
                state_d = IDLE;
                seq_d   = seq_q + 16'd1;
            end
        end
    end

    // Responses arrive in issue order, so the FIFO head always owns the current beat.
    assign head   = fifo_mem[rd_ptr_q];
    assign rsp_ok = rsp_in_valid && !fifo_empty;
    assign sop    = (beat_cnt_q == 6'd0);
    assign eop    = (beat_cnt_q == head[5:0]);
    assign pop    = rsp_ok && eop;

    always_comb begin
        wr_ptr_d        = wr_ptr_q + PTR_W'(push);
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
        cnt_d           = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        beat_cnt_d      = beat_cnt_q;
        if (rsp_ok)
            beat_cnt_d = eop ? 6'd0 : beat_cnt_q + 6'd1;
        afu_rsp_valid_d = rsp_ok;
        afu_rsp_data_d  = rsp_in_data;
        afu_rsp_tag_d   = head[ENT_W-1:6];
        afu_rsp_sop_d   = sop;
        afu_rsp_eop_d   = eop;
        err_underflow_d = err_underflow_q | (rsp_in_valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {req_tag, req_len};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            seq_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            beat_cnt_q      <= '0;
            afu_rsp_valid_q <= 1'b0;
            afu_rsp_data_q  <= '0;
            afu_rsp_tag_q   <= '0;
            afu_rsp_sop_q   <= 1'b0;
            afu_rsp_eop_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            seq_q           <= seq_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            afu_rsp_valid_q <= afu_rsp_valid_d;
            afu_rsp_data_q  <= afu_rsp_data_d;
            afu_rsp_tag_q   <= afu_rsp_tag_d;
            afu_rsp_sop_q   <= afu_rsp_sop_d;
            afu_rsp_eop_q   <= afu_rsp_eop_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign afu_rsp_valid = afu_rsp_valid_q;
    assign afu_rsp_data  = afu_rsp_data_q;
    assign afu_rsp_tag   = afu_rsp_tag_q;
    assign afu_rsp_sop   = afu_rsp_sop_q;
    assign afu_rsp_eop   = afu_rsp_eop_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_ofs_plat_shim_ccip_rd_burst_split.sv
// Bench for the read-burst splitter: queue-based model checked every cycle plus
// directed scenarios with literal expectations.
module tb_ofs_plat_shim_ccip_rd_burst_split;
    localparam int AW = 42;
    localparam int DW = 512;
    localparam int TW = 16;
    localparam int MB = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [5:0]    req_len = '0;
    logic [TW-1:0] req_tag = '0;
    logic          c0_tx_valid;
    logic [AW-1:0] c0_tx_addr;
    logic [1:0]    c0_tx_cl_len;
    logic [15:0]   c0_tx_mdata;
    logic          c0_tx_almfull = 1'b0;
    logic          rsp_in_valid = 1'b0;
    logic [DW-1:0] rsp_in_data = '0;
    logic          afu_rsp_valid;
    logic [DW-1:0] afu_rsp_data;
    logic [TW-1:0] afu_rsp_tag;
    logic          afu_rsp_sop, afu_rsp_eop, err_underflow;

    ofs_plat_shim_ccip_rd_burst_split #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_BURSTS(MB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_tag(req_tag),
        .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_cl_len(c0_tx_cl_len),
        .c0_tx_mdata(c0_tx_mdata), .c0_tx_almfull(c0_tx_almfull),
        .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data),
        .afu_rsp_valid(afu_rsp_valid), .afu_rsp_data(afu_rsp_data), .afu_rsp_tag(afu_rsp_tag),
        .afu_rsp_sop(afu_rsp_sop), .afu_rsp_eop(afu_rsp_eop), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [1:0] cl; logic [15:0] md; } req_t;
    typedef struct { logic [TW-1:0] tag; logic [5:0] len; } burst_t;
    typedef struct { logic [DW-1:0] data; logic [TW-1:0] tag; logic sop; logic eop; } beat_t;

    req_t   exp_req_q[$];
    burst_t bursts_q[$];
    req_t   req_log[$];
    beat_t  rsp_log[$];
    int     mbeat = 0;
    logic [15:0] mseq = '0;
    logic   merr = 1'b0;
    beat_t  pend;
    logic   pend_v = 1'b0;
    req_t   er;
    burst_t hb;
    int     checks = 0;
    int     failures = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected CCI-P requests for a burst: greedily take the largest aligned chunk that fits.
    function automatic void split(input logic [AW-1:0] addr, input logic [5:0] len, input logic [15:0] md);
        longint unsigned a = addr;
        int r = int'(len) + 1;
        int s;
        while (r > 0) begin
            if (a % 4 == 0 && r >= 4) s = 4;
            else if (a % 2 == 0 && r >= 2) s = 2;
            else s = 1;
            exp_req_q.push_back('{AW'(a), (s == 4) ? 2'd3 : (s == 2) ? 2'd1 : 2'd0, md});
            a += longint'(s);
            r -= s;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_req_q.delete();
            bursts_q.delete();
            mbeat = 0; mseq = '0; merr = 1'b0; pend_v = 1'b0;
        end else begin
            chk("afu_rsp_valid", afu_rsp_valid, pend_v);
            if (pend_v && afu_rsp_valid) begin
                chk("afu_rsp_data", afu_rsp_data, pend.data);
                chk("afu_rsp_tag", afu_rsp_tag, pend.tag);
                chk("afu_rsp_sop", afu_rsp_sop, pend.sop);
                chk("afu_rsp_eop", afu_rsp_eop, pend.eop);
                rsp_log.push_back('{afu_rsp_data, afu_rsp_tag, afu_rsp_sop, afu_rsp_eop});
            end
            chk("err_underflow", err_underflow, merr);
            chk("req_ready", req_ready, exp_req_q.size() == 0 && bursts_q.size() < MB);
            chk("c0_tx_valid", c0_tx_valid, exp_req_q.size() != 0 && !c0_tx_almfull);
            if (c0_tx_valid && exp_req_q.size() != 0) begin
                er = exp_req_q.pop_front();
                chk("c0_tx_addr", c0_tx_addr, er.addr);
                chk("c0_tx_cl_len", c0_tx_cl_len, er.cl);
                chk("c0_tx_mdata", c0_tx_mdata, er.md);
                req_log.push_back('{c0_tx_addr, c0_tx_cl_len, c0_tx_mdata});
            end
            pend_v = 1'b0;
            if (rsp_in_valid) begin
                if (bursts_q.size() == 0) merr = 1'b1;
                else begin
                    hb = bursts_q[0];
                    pend = '{rsp_in_data, hb.tag, mbeat == 0, mbeat == int'(hb.len)};
                    pend_v = 1'b1;
                    if (mbeat == int'(hb.len)) begin
                        void'(bursts_q.pop_front());
                        mbeat = 0;
                    end else mbeat++;
                end
            end
            if (req_valid && req_ready) begin
                bursts_q.push_back('{req_tag, req_len});
                split(req_addr, req_len, mseq);
                mseq++;
            end
        end
    end

    task automatic send_burst(input logic [AW-1:0] a, input logic [5:0] l, input logic [TW-1:0] t);
        logic ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_len = l; req_tag = t;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("burst_accepted", ok, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_rsp(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rsp_in_valid = 1'b1;
            rsp_in_data = {16{$urandom}};
        end
        @(posedge clk); #1;
        rsp_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 500; i++) begin
            @(posedge clk);
            if (exp_req_q.size() == 0) break;
        end
        chk("split_done_in_time", i < 500, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_burst_beats(input int r0, input int n, input logic [TW-1:0] t);
        chk("beat_count", rsp_log.size() - r0, n);
        for (int i = 0; i < n && r0 + i < rsp_log.size(); i++) begin
            chk("beat_tag", rsp_log[r0+i].tag, t);
            chk("beat_sop", rsp_log[r0+i].sop, i == 0);
            chk("beat_eop", rsp_log[r0+i].eop, i == n - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n0, r0, i;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_c0_tx_valid", c0_tx_valid, 1'b0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_afu_rsp_valid", afu_rsp_valid, 1'b0);
        chk("reset_err_underflow", err_underflow, 1'b0);

        // aligned 8-line burst
        n0 = req_log.size(); r0 = rsp_log.size();
        send_burst(42'h100, 6'd7, 16'h55);
        wait_idle();
        chk("aligned_nreq", req_log.size() - n0, 2);
        chk("aligned_a0", req_log[n0].addr, 42'h100);
        chk("aligned_c0", req_log[n0].cl, 2'd3);
        chk("aligned_a1", req_log[n0+1].addr, 42'h104);
        chk("aligned_c1", req_log[n0+1].cl, 2'd3);
        send_rsp(8);
        repeat (2) @(posedge clk);
        chk_burst_beats(r0, 8, 16'h55);

        // unaligned 7-line burst
        n0 = req_log.size(); r0 = rsp_log.size();
        send_burst(42'h101, 6'd6, 16'h66);
        wait_idle();
        chk("unal_nreq", req_log.size() - n0, 3);
        chk("unal_a0", req_log[n0].addr, 42'h101);
        chk("unal_c0", req_log[n0].cl, 2'd0);
        chk("unal_a1", req_log[n0+1].addr, 42'h102);
        chk("unal_c1", req_log[n0+1].cl, 2'd1);
        chk("unal_a2", req_log[n0+2].addr, 42'h104);
        chk("unal_c2", req_log[n0+2].cl, 2'd3);
        send_rsp(7);
        repeat (2) @(posedge clk);
        chk_burst_beats(r0, 7, 16'h66);

        // almfull for 3 cycles after the second request
        n0 = req_log.size(); r0 = rsp_log.size();
        send_burst(42'h100, 6'd15, 16'h77);
        for (i = 0; i < 50; i++) begin
            @(posedge clk);
            if (req_log.size() >= n0 + 2) break;
        end
        chk("almfull_second_req_seen", i < 50, 1'b1);
        #1 c0_tx_almfull = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("almfull_no_valid", c0_tx_valid, 1'b0);
        end
        @(posedge clk); #1 c0_tx_almfull = 1'b0;
        wait_idle();
        chk("almfull_nreq", req_log.size() - n0, 4);
        chk("almfull_a2", req_log[n0+2].addr, 42'h108);
        chk("almfull_a3", req_log[n0+3].addr, 42'h10C);
        send_rsp(16);
        repeat (2) @(posedge clk);
        chk_burst_beats(r0, 16, 16'h77);

        // back-to-back single-line bursts
        r0 = rsp_log.size();
        send_burst(42'h300, 6'd0, 16'd1);
        send_burst(42'h301, 6'd0, 16'd2);
        send_burst(42'h302, 6'd0, 16'd3);
        wait_idle();
        send_rsp(3);
        repeat (2) @(posedge clk);
        chk("b2b_count", rsp_log.size() - r0, 3);
        for (int k = 0; k < 3 && r0 + k < rsp_log.size(); k++) begin
            chk("b2b_tag", rsp_log[r0+k].tag, TW'(k + 1));
            chk("b2b_sop", rsp_log[r0+k].sop, 1'b1);
            chk("b2b_eop", rsp_log[r0+k].eop, 1'b1);
        end

        // fill the tag FIFO
        r0 = rsp_log.size();
        for (int k = 0; k < MB; k++) send_burst(42'h400 + AW'(k), 6'd0, TW'(16'h100 + k));
        wait_idle();
        @(negedge clk);
        chk("full_ready_low", req_ready, 1'b0);
        @(posedge clk); #1;
        rsp_in_valid = 1'b1; rsp_in_data = {16{$urandom}};
        @(negedge clk);
        chk("full_ready_low_on_pop", req_ready, 1'b0);
        @(posedge clk); #1 rsp_in_valid = 1'b0;
        @(negedge clk);
        chk("full_ready_after_pop", req_ready, 1'b1);
        send_rsp(MB - 1);
        repeat (2) @(posedge clk);
        chk("full_drain_count", rsp_log.size() - r0, MB);
        chk("full_last_tag", rsp_log[rsp_log.size()-1].tag, 16'h11F);

        // reset in the middle of a burst
        n0 = req_log.size();
        send_burst(42'h200, 6'd15, 16'h99);
        for (i = 0; i < 50; i++) begin
            @(posedge clk);
            if (req_log.size() >= n0 + 1) break;
        end
        chk("rst_first_req_seen", i < 50, 1'b1);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_c0_tx_valid", c0_tx_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_err_clear", err_underflow, 1'b0);
        @(posedge clk); #1;
        rsp_in_valid = 1'b1; rsp_in_data = {16{$urandom}};
        @(posedge clk); #1 rsp_in_valid = 1'b0;
        @(negedge clk);
        chk("underflow_set", err_underflow, 1'b1);
        chk("underflow_no_beat", afu_rsp_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("underflow_sticky", err_underflow, 1'b1);
        chk("model_drained", exp_req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ofs_plat_shim_ccip_rd_burst_split.md
# ofs_plat_shim_ccip_rd_burst_split

Read-burst splitter upstream of the CCI-P read ROB shim. Accepts AFU read bursts of 1–64 lines, splits each into CCI-P-legal 1/2/4-line aligned read requests, and throttles on c0TxAlmFull. Consumes the ROB shim's in-order read responses and re-tags them with burst tag, SOP and EOP. Because responses arrive in order, tag recovery needs only a FIFO and a beat counter.

## Interface
Parameters:
- ADDR_WIDTH, 42, cache-line address width
- DATA_WIDTH, 512, line data width
- TAG_WIDTH, 16, AFU burst tag width
- MAX_BURSTS, 32, tag FIFO depth; power of 2; max bursts in flight

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  AFU burst request valid
- req_ready  out  1  burst accepted when req_valid && req_ready
- req_addr  in  ADDR_WIDTH  first line address
- req_len  in  6  burst length minus 1 (0 → 1 line, 63 → 64 lines)
- req_tag  in  TAG_WIDTH  returned with every response beat
- c0_tx_valid  out  1  CCI-P read request valid
- c0_tx_addr  out  ADDR_WIDTH  request line address
- c0_tx_cl_len  out  2  0 = 1 line, 1 = 2 lines, 3 = 4 lines
- c0_tx_mdata  out  16  low bits: burst sequence number (debug only)
- c0_tx_almfull  in  1  c0TxAlmFull from the ROB shim
- rsp_in_valid  in  1  ordered read response beat from the ROB shim
- rsp_in_data  in  DATA_WIDTH  response data
- afu_rsp_valid  out  1  burst response beat valid
- afu_rsp_data  out  DATA_WIDTH  beat data
- afu_rsp_tag  out  TAG_WIDTH  tag of the owning burst
- afu_rsp_sop  out  1  first beat of a burst
- afu_rsp_eop  out  1  last beat of a burst
- err_underflow  out  1  sticky: a response arrived with the tag FIFO empty

## Operation
- Request FSM has two states, IDLE and SPLIT. Registers: cur_addr, remaining (7 bits, lines left), seq (16 bits).
- req_ready = (state == IDLE) && tag FIFO not full.
- On accept:
  - cur_addr ← req_addr; remaining ← req_len + 1; state ← SPLIT.
  - Push {req_tag, req_len} into the tag FIFO.
- In SPLIT, c0_tx_valid = !c0_tx_almfull. Request size is chosen as follows:
  - 4 lines if cur_addr[1:0] == 0 and remaining ≥ 4
  - else 2 lines if cur_addr[0] == 0 and remaining ≥ 2
  - else 1 line
- On each issued request:
  - cur_addr += size; remaining −= size.
  - If remaining == size, state ← IDLE and seq += 1.
- c0_tx_addr = cur_addr; c0_tx_mdata = seq. The ROB shim overwrites mdata in flight and restores it on the response.
- Outputs are never multi-line requests that cross a 4-line-aligned boundary, so a 4 KB page is never crossed within one request.
- Response side: beat_cnt (6 bits) is compared with the req_len stored at the tag FIFO head.
  - On rsp_in_valid: sop = (beat_cnt == 0); eop = (beat_cnt == head_len).
  - On eop: pop the FIFO and set beat_cnt ← 0. Otherwise beat_cnt += 1.
- rsp_in_valid with the FIFO empty: drop the beat, set err_underflow, emit nothing.
- Same-cycle FIFO push and pop are both honoured. A full FIFO with a simultaneous pop still deasserts req_ready that cycle; ready rises the next cycle.
- No response backpressure: CCI-P responses cannot be stalled.
- Reset values: state IDLE, FIFO empty, beat_cnt 0, seq 0, err_underflow 0, all valid outputs 0.
- Reset mid-burst discards the remaining split requests and all tags. The bench must not deliver pre-reset responses after reset.

## Timing
- Burst accepted at cycle T → first c0_tx_valid at T+1 at the earliest.
- One CCI-P request per cycle while !c0_tx_almfull. The next burst can be accepted in the cycle after the final request issues.
- c0_tx_* is combinational from state registers and c0_tx_almfull. Issue stops in the same cycle almfull rises, well inside the CCI-P almost-full allowance.
- afu_rsp_* is registered: rsp_in at cycle T → afu_rsp at T+1. Beats are back-to-back capable.
- A 64-line aligned burst issues 16 requests in 16 cycles.

## Test plan
- Aligned burst: addr 0x100, len 7, tag 0x55 → requests (0x100, cl_len 3) then (0x104, cl_len 3) on consecutive cycles. Eight response beats → eight outputs with tag 0x55, sop on beat 0, eop on beat 7.
- Unaligned burst: addr 0x101, len 6 → requests (0x101, 0), (0x102, 1), (0x104, 3). Seven beats, eop on the 7th.
- Almfull: 16-line aligned burst with almfull high for 3 cycles after the 2nd request → no valid during those cycles, then 0x108 and 0x10C issue. Exactly 4 requests total.
- FIFO full: 32 single-line bursts with no responses → req_ready low. One response beat (eop) → req_ready high the next cycle.
- Back-to-back len 0 bursts with tags 1, 2, 3 and three responses → each beat has sop = eop = 1, tags in order 1, 2, 3.
- Reset mid-burst: assert reset_n low during the 2nd request of a 16-line burst → c0_tx_valid low, req_ready high after release. A response with no burst outstanding sets err_underflow.
